// File: rtl/dec8_pkg.sv
// Shared constants, state encoding and digit helper for the packed-BCD to binary converter.
package dec8_pkg;

  localparam int unsigned NDIG    = 8;
  localparam int unsigned BIN_W   = 27;
  localparam int unsigned DEC_W   = 32;
  localparam int unsigned PTR_W   = 4;
  localparam int unsigned DEC_MAX = 99_999_999;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/dec8_to_bin27_mul10_add.sv
// One Horner step: o_sum = i_acc*10 + i_dig using shift-add only.
module mul10_add
  import dec8_pkg::*;
(
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_dig,
  output logic [BIN_W-1:0] o_sum
);

  assign o_sum = (i_acc << 3) + (i_acc << 1) + BIN_W'(i_dig);

endmodule

// File: rtl/dec8_to_bin27.sv
// Sequential 8-digit packed-BCD to 27-bit binary converter, one digit per clock, MSD first.
module dec8_to_bin27
  import dec8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             st,
  input  logic [DEC_W-1:0] DEC,
  output logic [BIN_W-1:0] BIN,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e             r_state, w_state;
  logic [PTR_W-1:0]   r_ptr, w_ptr;
  logic [BIN_W-1:0]   r_acc, w_acc;
  logic [DEC_W-1:0]   r_shift, w_shift;
  logic [BIN_W-1:0]   r_bin, w_bin;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic [3:0]         w_dig;
  logic [BIN_W-1:0]   w_sum;

  assign w_dig = r_shift[DEC_W-1 -: 4];

  mul10_add u_mul10_add (
    .i_acc (r_acc),
    .i_dig (w_dig),
    .o_sum (w_sum)
  );

  // State and output registers; reset dominates start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_acc   <= '0;
      r_shift <= '0;
      r_bin   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_acc   <= w_acc;
      r_shift <= w_shift;
      r_bin   <= w_bin;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  // Next-state logic; a start restarts any conversion in flight without a done.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_acc   = r_acc;
    w_shift = r_shift;
    w_bin   = r_bin;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = r_err;

    if (st) begin
      w_state = RUN;
      w_shift = DEC;
      w_acc   = '0;
      w_ptr   = PTR_W'(NDIG);
      w_busy  = 1'b1;
      w_err   = 1'b0;
    end else if (r_state == RUN) begin
      if (!is_bcd(w_dig)) begin
        w_state = IDLE;
        w_bin   = '0;
        w_err   = 1'b1;
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_ptr   = '0;
      end else begin
        w_acc   = w_sum;
        w_shift = r_shift << 4;
        w_ptr   = r_ptr - PTR_W'(1);
        if (r_ptr == PTR_W'(1)) begin
          w_state = IDLE;
          w_bin   = w_sum;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end
      end
    end
  end

  assign BIN  = r_bin;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_dec8_to_bin27.sv
// Self-checking bench: directed cases plus random BCD words against a positional-value model.
module tb_dec8_to_bin27;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [31:0] DEC;
  logic [26:0] BIN;
  logic        busy, done, err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [26:0] last_bin;

  dec8_to_bin27 dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .DEC  (DEC),
    .BIN  (BIN),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value = sum of digit * 10^position; first non-decimal nibble from the MSD aborts.
  task automatic model(input logic [31:0] dec, output logic [26:0] b, output logic e,
                       output int lat);
    longint val = 0;
    longint pw  = 1;
    logic [31:0] w = dec;
    e = 1'b0; lat = 8;
    for (int j = 1; j <= 8; j++) begin
      if (w[31-4*(j-1) -: 4] > 4'd9) begin
        e = 1'b1; lat = j; b = '0;
        return;
      end
    end
    for (int p = 0; p < 8; p++) begin
      val += longint'(w[4*p +: 4]) * pw;
      pw  *= 10;
    end
    b = 27'(val);
  endtask

  task automatic start(input logic [31:0] dec);
    @(negedge clk);
    st = 1'b1; DEC = dec;
    @(posedge clk); #1;
    st = 1'b0; DEC = $urandom;
    chk("busy_at_start", 32'(busy), 32'd1);
    chk("done_at_start", 32'(done), 32'd0);
    chk("bin_hold_at_st", 32'(BIN), 32'(last_bin));
  endtask

  // Wait for done and check latency, result and flags; leaves the bench in the done cycle.
  task automatic finish_conv(input logic [31:0] dec);
    logic [26:0] eb; logic ee; int el; int n;
    model(dec, eb, ee, el);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy !== 1'b1) begin
        chk("busy_mid", 32'(busy), 32'd1);
        break;
      end
    end
    chk("latency", 32'(n), 32'(el));
    chk("bin", 32'(BIN), 32'(eb));
    chk("err", 32'(err), 32'(ee));
    chk("busy_at_done", 32'(busy), 32'd0);
    last_bin = eb;
  endtask

  task automatic after_done(input logic exp_err);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("err_hold", 32'(err), 32'(exp_err));
    chk("bin_hold", 32'(BIN), 32'(last_bin));
  endtask

  task automatic conv(input logic [31:0] dec);
    logic [26:0] eb; logic ee; int el;
    model(dec, eb, ee, el);
    start(dec);
    finish_conv(dec);
    after_done(ee);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; st = 1'b0; DEC = '0; last_bin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", 32'(BIN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b0;

    conv(32'h00000000);
    conv(32'h99999999);
    chk("bin_max", 32'(BIN), 32'h05F5E0FF);

    // Back-to-back: second start lands in the done cycle.
    start(32'h12345678);
    finish_conv(32'h12345678);
    chk("bin_12345678", 32'(BIN), 32'h00BC614E);
    start(32'h00000001);
    finish_conv(32'h00000001);
    after_done(1'b0);

    conv(32'h1A345678);
    conv(32'h0000000F);

    // Restart mid-conversion: only the second value completes.
    start(32'h00000555);
    repeat (2) begin
      @(posedge clk); #1;
      chk("no_done_before_restart", 32'(done), 32'd0);
    end
    start(32'h00000042);
    finish_conv(32'h00000042);
    after_done(1'b0);

    // Reset at k+4 clears everything and nothing completes afterwards.
    start(32'h87654321);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_bin", 32'(BIN), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b0;
    last_bin = '0;
    begin
      int seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      chk("no_done_after_rst", 32'(seen), 32'd0);
    end

    for (int t = 0; t < 150; t++) begin
      d = '0;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 19) == 0) d[4*i +: 4] = 4'($urandom_range(10, 15));
        else                            d[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 1) == 0) begin
        conv(d);
      end else begin
        start(d);
        finish_conv(d);
      end
    end
    after_done(err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
